// File: rtl/h80cpu_uart_rx_io_pkg.sv
// Shared bus types, I/O register addresses and state encodings for the h80 UART receiver.
package h80cpu_uart_rx_io_pkg;

    typedef logic [15:0] bus_addr_t;
    typedef logic [15:0] bus_data_t;

    typedef enum logic [1:0] {
        bus_cmd_idle_b  = 2'd0,
        bus_cmd_read_b  = 2'd1,
        bus_cmd_write_b = 2'd2,
        bus_cmd_rsvd_b  = 2'd3
    } bus_cmd_t;

    localparam bus_addr_t H80_IO_UART_RXDATA = 16'h0001;
    localparam bus_addr_t H80_IO_UART_STATUS = 16'h0002;

    typedef enum logic [1:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_STOP
    } rx_state_t;

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT_RX,
        S_HOLD
    } bus_state_t;

    // Clocks per 16x oversample tick; never below one.
    function automatic int unsigned os_divisor(input int unsigned clk_freq,
                                               input int unsigned uart_freq);
        int unsigned div;
        div = clk_freq / (uart_freq * 16);
        return (div == 0) ? 1 : div;
    endfunction

endpackage

// File: rtl/h80cpu_uart_rx_io_uart_rx_V2.sv
// 8N1 deserialiser: 2-FF synchroniser, 16x oversampler and frame FSM.
module uart_rx_V2
    import h80cpu_uart_rx_io_pkg::*;
#(
    parameter int unsigned clk_freq  = 50000000,
    parameter int unsigned uart_freq = 115200
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       uart_rxp,
    output logic       rx_strobe,
    output logic [7:0] rx_byte,
    output logic       rx_ferr
);

    localparam int unsigned Div  = os_divisor(clk_freq, uart_freq);
    localparam int unsigned DivW = (Div > 1) ? $clog2(Div) : 1;

    rx_state_t         state_q, state_d;
    logic              sync1_q, sync2_q, prev_q;
    logic [DivW-1:0]   div_q, div_d;
    logic [3:0]        os_q, os_d;
    logic [2:0]        bit_q, bit_d;
    logic [7:0]        shift_q, shift_d;
    logic              tick;

    assign tick    = (div_q == DivW'(Div - 1));
    assign rx_byte = shift_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
            prev_q  <= 1'b1;
            state_q <= RX_IDLE;
            div_q   <= '0;
            os_q    <= '0;
            bit_q   <= '0;
            shift_q <= '0;
        end else begin
            sync1_q <= uart_rxp;
            sync2_q <= sync1_q;
            prev_q  <= sync2_q;
            state_q <= state_d;
            div_q   <= div_d;
            os_q    <= os_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        div_d     = div_q;
        os_d      = os_q;
        bit_d     = bit_q;
        shift_d   = shift_q;
        rx_strobe = 1'b0;
        rx_ferr   = 1'b0;
        if (state_q != RX_IDLE) begin
            div_d = tick ? '0 : div_q + 1'b1;
            if (tick) begin
                os_d = os_q + 4'd1;
            end
        end
        unique case (state_q)
            RX_IDLE: begin
                // Oversampler phase is anchored to the start-bit edge.
                if (prev_q && !sync2_q) begin
                    state_d = RX_START;
                    div_d   = '0;
                    os_d    = '0;
                end
            end
            RX_START: begin
                if (tick && os_q == 4'd7) begin
                    os_d    = '0;
                    bit_d   = '0;
                    state_d = sync2_q ? RX_IDLE : RX_DATA;
                end
            end
            RX_DATA: begin
                if (tick && os_q == 4'd15) begin
                    shift_d = {sync2_q, shift_q[7:1]};
                    bit_d   = bit_q + 3'd1;
                    if (bit_q == 3'd7) begin
                        state_d = RX_STOP;
                    end
                end
            end
            RX_STOP: begin
                if (tick && os_q == 4'd15) begin
                    state_d   = RX_IDLE;
                    rx_strobe = sync2_q;
                    rx_ferr   = !sync2_q;
                end
            end
            default: state_d = RX_IDLE;
        endcase
    end

endmodule

// File: rtl/h80cpu_uart_rx_io.sv
// Bus-mapped UART receiver: byte buffer, sticky flags and stalling bus FSM.
// Define H80CPU_UART_RX_FIFO_EN for a FIFO_DEPTH-entry FIFO instead of a holding register.
module h80cpu_uart_rx_io
    import h80cpu_uart_rx_io_pkg::*;
#(
    parameter int unsigned clk_freq   = 50000000,
    parameter int unsigned uart_freq  = 115200,
    parameter int unsigned FIFO_DEPTH = 16
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           ce_n,
    input  bus_addr_t      addr,
    input  bus_cmd_t       cmd,
    inout  wire bus_data_t data,
    output logic           wait_n,
    input  logic           uart_rxp
);

    logic       rx_strobe, rx_ferr;
    logic [7:0] rx_byte;
    logic [7:0] head;
    logic       empty, full, pop, push_ok;

    uart_rx_V2 #(
        .clk_freq (clk_freq),
        .uart_freq(uart_freq)
    ) u_rx (
        .clk      (clk),
        .reset    (reset),
        .uart_rxp (uart_rxp),
        .rx_strobe(rx_strobe),
        .rx_byte  (rx_byte),
        .rx_ferr  (rx_ferr)
    );

    // A pop on the same edge frees the slot for the incoming byte.
    assign push_ok = rx_strobe && (!full || pop);

`ifdef H80CPU_UART_RX_FIFO_EN
    localparam int unsigned Aw = $clog2(FIFO_DEPTH);

    logic [7:0]  mem_q [FIFO_DEPTH];
    logic [Aw:0] wr_q, wr_d, rd_q, rd_d;

    assign empty = (wr_q == rd_q);
    assign full  = (wr_q[Aw] != rd_q[Aw]) && (wr_q[Aw-1:0] == rd_q[Aw-1:0]);
    assign head  = mem_q[rd_q[Aw-1:0]];

    always_comb begin
        wr_d = wr_q + {{Aw{1'b0}}, push_ok};
        rd_d = rd_q + {{Aw{1'b0}}, pop};
    end

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem_q[wr_q[Aw-1:0]] <= rx_byte;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_q <= '0;
            rd_q <= '0;
        end else begin
            wr_q <= wr_d;
            rd_q <= rd_d;
        end
    end
`else
    logic [7:0] hold_q, hold_d;
    logic       valid_q, valid_d;
    logic       unused_depth;

    assign unused_depth = ^FIFO_DEPTH;
    assign empty        = !valid_q;
    assign full         = valid_q;
    assign head         = hold_q;

    always_comb begin
        hold_d  = push_ok ? rx_byte : hold_q;
        valid_d = push_ok ? 1'b1 : (pop ? 1'b0 : valid_q);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hold_q  <= '0;
            valid_q <= 1'b0;
        end else begin
            hold_q  <= hold_d;
            valid_q <= valid_d;
        end
    end
`endif

    bus_state_t bus_q, bus_d;
    logic       ovr_q, ovr_d, ferr_q, ferr_d;
    logic       sel_rx, sel_st, st_clr, stall;
    bus_data_t  dout;

    assign sel_rx = !ce_n && (cmd == bus_cmd_read_b) && (addr == H80_IO_UART_RXDATA);
    assign sel_st = !ce_n && (cmd == bus_cmd_read_b) && (addr == H80_IO_UART_STATUS);

    always_comb begin
        bus_d  = bus_q;
        stall  = 1'b0;
        pop    = 1'b0;
        st_clr = 1'b0;
        unique case (bus_q)
            S_IDLE: begin
                if (sel_rx) begin
                    if (empty) begin
                        stall = 1'b1;
                        bus_d = S_WAIT_RX;
                    end else begin
                        pop   = 1'b1;
                        bus_d = S_HOLD;
                    end
                end else if (sel_st) begin
                    st_clr = 1'b1;
                    bus_d  = S_HOLD;
                end
            end
            S_WAIT_RX: begin
                if (!sel_rx) begin
                    bus_d = S_IDLE;
                end else if (empty) begin
                    stall = 1'b1;
                end else begin
                    pop   = 1'b1;
                    bus_d = S_HOLD;
                end
            end
            // Access already serviced; wait for deselection so a long read pops once.
            S_HOLD: begin
                if (!sel_rx && !sel_st) begin
                    bus_d = S_IDLE;
                end
            end
            default: bus_d = S_IDLE;
        endcase
    end

    always_comb begin
        ovr_d  = st_clr ? 1'b0 : ovr_q;
        ferr_d = st_clr ? 1'b0 : ferr_q;
        if (rx_strobe && !push_ok) begin
            ovr_d = 1'b1;
        end
        if (rx_ferr) begin
            ferr_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bus_q  <= S_IDLE;
            ovr_q  <= 1'b0;
            ferr_q <= 1'b0;
        end else begin
            bus_q  <= bus_d;
            ovr_q  <= ovr_d;
            ferr_q <= ferr_d;
        end
    end

    always_comb begin
        dout = '0;
        if (sel_rx) begin
            dout[7:0] = head;
        end else begin
            dout[3:0] = {full, ferr_q, ovr_q, !empty};
        end
    end

    // No stall may be presented while reset is held, even with a read pending.
    assign wait_n = !(stall && !reset);
    assign data   = (sel_rx || sel_st) ? dout : 'z;

endmodule

// File: tb/tb_h80cpu_uart_rx_io.sv
// Self-checking bench for h80cpu_uart_rx_io with a queue-based reference model.
module tb_h80cpu_uart_rx_io;
    import h80cpu_uart_rx_io_pkg::*;

    localparam int unsigned CLK_FREQ   = 50000000;
    localparam int unsigned UART_FREQ  = 1000000;
    localparam int unsigned FIFO_DEPTH = 16;
    localparam int BIT      = int'((CLK_FREQ / (UART_FREQ * 16)) * 16);
    localparam int FRAME    = 11 * BIT;
    localparam int STOP_MID = 9 * BIT + BIT / 2;
`ifdef H80CPU_UART_RX_FIFO_EN
    localparam int CAP = FIFO_DEPTH;
`else
    localparam int CAP = 1;
`endif

    logic      clk = 1'b0;
    logic      reset = 1'b1;
    logic      ce_n = 1'b1;
    bus_addr_t addr = '0;
    bus_cmd_t  cmd = bus_cmd_idle_b;
    wire bus_data_t data;
    logic      wait_n;
    logic      uart_rxp = 1'b1;

    logic      abort_tx = 1'b0;
    logic      tx_busy = 1'b0;

    int n_tests = 0;
    int n_fail  = 0;

    logic [7:0] mq[$];
    logic       m_ovr = 1'b0;
    logic       m_ferr = 1'b0;

    h80cpu_uart_rx_io #(
        .clk_freq  (CLK_FREQ),
        .uart_freq (UART_FREQ),
        .FIFO_DEPTH(FIFO_DEPTH)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .ce_n    (ce_n),
        .addr    (addr),
        .cmd     (cmd),
        .data    (data),
        .wait_n  (wait_n),
        .uart_rxp(uart_rxp)
    );

    always #5 clk = ~clk;

    function automatic void model_push(input logic [7:0] b);
        if (mq.size() < CAP) mq.push_back(b);
        else m_ovr = 1'b1;
    endfunction

    function automatic bus_data_t model_status();
        return {12'd0, mq.size() == CAP, m_ferr, m_ovr, mq.size() != 0};
    endfunction

    task automatic cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_frame(input logic [7:0] b, input logic stop_bit);
        logic [10:0] bits;
        bits = {1'b1, stop_bit, b, 1'b0};
        tx_busy = 1'b1;
        for (int i = 0; i < 11 && !abort_tx; i++) begin
            uart_rxp = bits[i[3:0]];
            for (int c = 0; c < BIT && !abort_tx; c++) begin
                @(posedge clk);
                #1;
            end
        end
        uart_rxp = 1'b1;
        tx_busy = 1'b0;
    endtask

    task automatic bus_read(input bus_addr_t a, output bus_data_t d, output logic ok);
        int cyc;
        cyc = 0;
        ce_n = 1'b0;
        cmd = bus_cmd_read_b;
        addr = a;
        #1;
        while (wait_n !== 1'b1 && cyc < 4 * FRAME) begin
            @(posedge clk);
            #1;
            cyc++;
        end
        ok = (wait_n === 1'b1);
        d = data;
        cycles(1);
        ce_n = 1'b1;
        cmd = bus_cmd_idle_b;
        addr = '0;
        cycles(1);
    endtask

    task automatic test_reset();
        bus_data_t d;
        logic ok;
        #1;
        n_tests++;
        if (wait_n !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_wait_n got=%b exp=1", wait_n);
        end
        cycles(3);
        reset = 1'b0;
        cycles(2);
        bus_read(H80_IO_UART_STATUS, d, ok);
        n_tests++;
        if (!ok || d !== 16'h0000) begin
            n_fail++;
            $display("FAIL reset_status got=%h ok=%b exp=0000", d, ok);
        end
    endtask

    task automatic test_single_frame();
        bus_data_t d, exp;
        logic ok;
        send_frame(8'h55, 1'b1);
        model_push(8'h55);
        bus_read(H80_IO_UART_STATUS, d, ok);
        exp = model_status();
        m_ovr = 1'b0;
        m_ferr = 1'b0;
        n_tests++;
        if (!ok || d !== exp) begin
            n_fail++;
            $display("FAIL single_status got=%h exp=%h", d, exp);
        end
        bus_read(H80_IO_UART_RXDATA, d, ok);
        exp = {8'h00, mq.pop_front()};
        n_tests++;
        if (!ok || d !== exp) begin
            n_fail++;
            $display("FAIL single_data got=%h exp=%h", d, exp);
        end
        bus_read(H80_IO_UART_STATUS, d, ok);
        n_tests++;
        if (!ok || d !== 16'h0000) begin
            n_fail++;
            $display("FAIL single_status_after got=%h exp=0000", d);
        end
    endtask

    task automatic test_blocking_read();
        bus_data_t d, exp;
        logic ok;
        int cyc;
        ce_n = 1'b0;
        cmd = bus_cmd_read_b;
        addr = H80_IO_UART_RXDATA;
        abort_tx = 1'b0;
        fork
            send_frame(8'hA3, 1'b1);
        join_none
        #0;
        cyc = 0;
        n_tests++;
        if (wait_n !== 1'b0) begin
            n_fail++;
            $display("FAIL block_stall got=%b exp=0", wait_n);
        end
        while (wait_n !== 1'b1 && cyc < 2 * FRAME) begin
            @(posedge clk);
            #1;
            cyc++;
        end
        n_tests++;
        if (cyc < STOP_MID - 2 || cyc > STOP_MID + 8) begin
            n_fail++;
            $display("FAIL block_release_cycle got=%0d exp=%0d..%0d", cyc, STOP_MID - 2,
                     STOP_MID + 8);
        end
        model_push(8'hA3);
        exp = {8'h00, mq.pop_front()};
        d = data;
        n_tests++;
        if (d !== exp) begin
            n_fail++;
            $display("FAIL block_data got=%h exp=%h", d, exp);
        end
        cycles(1);
        ce_n = 1'b1;
        cmd = bus_cmd_idle_b;
        while (tx_busy) cycles(1);
        cycles(2);
        bus_read(H80_IO_UART_STATUS, d, ok);
        exp = model_status();
        n_tests++;
        if (!ok || d !== exp) begin
            n_fail++;
            $display("FAIL block_status_after got=%h exp=%h", d, exp);
        end
    endtask

    task automatic test_overrun();
        bus_data_t d, exp;
        logic ok;
        for (int i = 0; i <= CAP; i++) begin
            send_frame(8'(i), 1'b1);
            model_push(8'(i));
        end
        bus_read(H80_IO_UART_STATUS, d, ok);
        m_ovr = 1'b0;
        n_tests++;
        if (!ok || d !== 16'h000B) begin
            n_fail++;
            $display("FAIL overrun_status got=%h exp=000b", d);
        end
        while (mq.size() != 0) begin
            bus_read(H80_IO_UART_RXDATA, d, ok);
            exp = {8'h00, mq.pop_front()};
            n_tests++;
            if (!ok || d !== exp) begin
                n_fail++;
                $display("FAIL overrun_data got=%h exp=%h", d, exp);
            end
        end
        bus_read(H80_IO_UART_STATUS, d, ok);
        n_tests++;
        if (!ok || d !== 16'h0000) begin
            n_fail++;
            $display("FAIL overrun_status_after got=%h exp=0000", d);
        end
    endtask

    task automatic test_frame_error();
        bus_data_t d, exp;
        logic ok;
        send_frame(8'h7E, 1'b0);
        m_ferr = 1'b1;
        bus_read(H80_IO_UART_STATUS, d, ok);
        m_ferr = 1'b0;
        n_tests++;
        if (!ok || d !== 16'h0004) begin
            n_fail++;
            $display("FAIL ferr_status got=%h exp=0004", d);
        end
        send_frame(8'h12, 1'b1);
        model_push(8'h12);
        bus_read(H80_IO_UART_RXDATA, d, ok);
        exp = {8'h00, mq.pop_front()};
        n_tests++;
        if (!ok || d !== exp) begin
            n_fail++;
            $display("FAIL ferr_next_data got=%h exp=%h", d, exp);
        end
    endtask

    task automatic test_glitch();
        bus_data_t d;
        logic ok;
        uart_rxp = 1'b0;
        cycles(4);
        uart_rxp = 1'b1;
        cycles(2 * BIT);
        bus_read(H80_IO_UART_STATUS, d, ok);
        n_tests++;
        if (!ok || d !== 16'h0000) begin
            n_fail++;
            $display("FAIL glitch_status got=%h exp=0000", d);
        end
    endtask

    task automatic test_random();
        bus_data_t d, exp;
        logic ok;
        logic [7:0] b;
        logic stop_bit;
        int n;
        for (int it = 0; it < 6; it++) begin
            n = int'($urandom_range(1, 3));
            for (int k = 0; k < n; k++) begin
                b = 8'($urandom_range(0, 255));
                stop_bit = ($urandom_range(0, 3) != 0);
                send_frame(b, stop_bit);
                if (stop_bit) model_push(b);
                else m_ferr = 1'b1;
            end
            bus_read(H80_IO_UART_STATUS, d, ok);
            exp = model_status();
            m_ovr = 1'b0;
            m_ferr = 1'b0;
            n_tests++;
            if (!ok || d !== exp) begin
                n_fail++;
                $display("FAIL rand_status it=%0d got=%h exp=%h", it, d, exp);
            end
            while (mq.size() != 0) begin
                bus_read(H80_IO_UART_RXDATA, d, ok);
                exp = {8'h00, mq.pop_front()};
                n_tests++;
                if (!ok || d !== exp) begin
                    n_fail++;
                    $display("FAIL rand_data it=%0d got=%h exp=%h", it, d, exp);
                end
            end
        end
    endtask

    task automatic test_reset_mid();
        bus_data_t d, exp;
        logic ok;
        ce_n = 1'b0;
        cmd = bus_cmd_read_b;
        addr = H80_IO_UART_RXDATA;
        abort_tx = 1'b0;
        fork
            send_frame(8'hC7, 1'b1);
        join_none
        cycles(4 * BIT);
        n_tests++;
        if (wait_n !== 1'b0) begin
            n_fail++;
            $display("FAIL rstmid_stall got=%b exp=0", wait_n);
        end
        #2;
        reset = 1'b1;
        #1;
        n_tests++;
        if (wait_n !== 1'b1) begin
            n_fail++;
            $display("FAIL rstmid_wait_n got=%b exp=1", wait_n);
        end
        addr = H80_IO_UART_STATUS;
        #1;
        n_tests++;
        if (data !== 16'h0000) begin
            n_fail++;
            $display("FAIL rstmid_status got=%h exp=0000", data);
        end
        abort_tx = 1'b1;
        ce_n = 1'b1;
        cmd = bus_cmd_idle_b;
        addr = '0;
        while (tx_busy) cycles(1);
        mq.delete();
        m_ovr = 1'b0;
        m_ferr = 1'b0;
        cycles(3);
        reset = 1'b0;
        abort_tx = 1'b0;
        cycles(BIT);
        send_frame(8'h3C, 1'b1);
        model_push(8'h3C);
        bus_read(H80_IO_UART_STATUS, d, ok);
        exp = model_status();
        n_tests++;
        if (!ok || d !== exp) begin
            n_fail++;
            $display("FAIL rstmid_after_status got=%h exp=%h", d, exp);
        end
        bus_read(H80_IO_UART_RXDATA, d, ok);
        exp = {8'h00, mq.pop_front()};
        n_tests++;
        if (!ok || d !== exp) begin
            n_fail++;
            $display("FAIL rstmid_after_data got=%h exp=%h", d, exp);
        end
    endtask

    initial begin
        test_reset();
        test_single_frame();
        test_blocking_read();
        test_overrun();
        test_frame_error();
        test_glitch();
        test_random();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog expired tests=%0d", n_tests);
        $fatal(1, "watchdog");
    end

endmodule
